sram_controller: RTL
====================

Name: sram_controller

Overview:
- Sequencer between the ARM pipeline MEM stage and the external 16-bit SRAM.
- Converts each 32-bit word load/store into two consecutive 16-bit SRAM accesses: low half first, then high half.
- Drives `ready` low to freeze the pipeline while a transaction is in flight.
- Owns the SRAM bus: SRAM_ADDR, SRAM_WE_N and the tri-state SRAM_DQ.

Parameters:
BASE_ADDR, 1024, byte address mapped to SRAM word 0; subtracted before mapping.
ACCESS_CYCLES, 2, clock cycles spent on each half-word access (must be ≥1).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset.
wr_en  input  1  store request from MEM stage; held stable until ready=1.
rd_en  input  1  load request from MEM stage; held stable until ready=1.
address  input  32  byte address of word access.
writeData  input  32  store data.
readData  output  32  load result; holds its value until the next read completes.
ready  output  1  0 = pipeline must freeze.
SRAM_ADDR  output  18  half-word address to the SRAM.
SRAM_WE_N  output  1  SRAM write strobe, active-low.
SRAM_DQ  inout  16  SRAM data bus; driven only during write phases, otherwise high-Z.

Behaviour:
- States:
  - IDLE, LOW, HIGH, DONE.
  - Phase counter `cnt`, range 0..ACCESS_CYCLES-1.
- IDLE:
  - If wr_en|rd_en, latch op (wr_en has priority when both are high), address and writeData into internal registers.
  - Then go to LOW with cnt=0.
- LOW and HIGH:
  - Each lasts exactly ACCESS_CYCLES cycles.
  - On the last cycle (cnt==ACCESS_CYCLES-1), LOW→HIGH and HIGH→DONE; cnt resets to 0.
- DONE: one cycle, then unconditionally to IDLE.
- Address mapping:
  - word = (latched address − BASE_ADDR) >> 2, 32-bit unsigned subtraction.
  - SRAM_ADDR = {word[16:0],1'b0} in LOW and {word[16:0],1'b1} in HIGH.
  - Out-of-range addresses wrap modulo 2^17 words; no error is flagged.
  - SRAM_ADDR = 0 in IDLE and DONE.
- Write op:
  - SRAM_WE_N=0 for every cycle of LOW and HIGH; 1 otherwise.
  - SRAM_DQ = data[15:0] in LOW and data[31:16] in HIGH.
  - Repeated identical writes within a phase are harmless.
- Read op:
  - SRAM_WE_N=1 and SRAM_DQ=high-Z throughout.
  - On the last LOW cycle, capture SRAM_DQ into readData[15:0].
  - On the last HIGH cycle, capture SRAM_DQ into readData[31:16].
  - readData is unchanged by writes.
- ready (combinational):
  - ready = ~(wr_en|rd_en) | (state==DONE).
  - From request presentation to ready=1, latency is 1+2·ACCESS_CYCLES cycles (5 at default).
- Back-to-back requests:
  - After DONE, IDLE accepts a request still asserted in the same cycle.
  - The requester must deassert or change the request on the edge ending DONE, since the pipeline advances there.
- Request dropped mid-transaction (protocol violation): the transaction completes anyway on latched values; ready follows the formula above.
- Reset (rst=0, any time, including mid-transaction):
  - state=IDLE, cnt=0, readData=0, latched regs=0.
  - SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=high-Z.
  - ready = ~(wr_en|rd_en).
  - A write interrupted by reset may leave one half updated; this is acceptable.
- SRAM_DQ is never driven in the same cycle as SRAM_WE_N=1 (no bus contention).

Test Plan:
1. Reset, then wr_en=1, address=1024, writeData=0xDEADBEEF.
   - ready=0 for 5 cycles, then 1.
   - SRAM word 0 = 0xBEEF, word 1 = 0xDEAD.
   - WE_N low exactly 4 cycles.
2. After test 1, rd_en=1, address=1024.
   - ready rises on cycle 5.
   - readData=0xDEADBEEF.
   - SRAM_DQ never driven by the controller.
3. Write 0x12345678 to address 1032, then read 1024 and 1032 back-to-back without idle gap.
   - SRAM_ADDR sequence 4,5 for 1032.
   - Reads return 0xDEADBEEF then 0x12345678.
   - Each read takes 5 stall cycles.
4. wr_en=1 and rd_en=1 simultaneously, address=1028, writeData=0xA5A5_5A5A.
   - Treated as a write: SRAM words 2,3 = 0x5A5A, 0xA5A5.
   - readData unchanged.
5. Assert rst=0 during HIGH of a read.
   - Outputs immediately reset: WE_N=1, DQ=Z, readData=0.
   - After release with rd_en held, a full 5-cycle read restarts and returns the correct data.
6. Set ACCESS_CYCLES=1 and read address 1024+4·0x1FFFF, plus one wrapping address 1024+4·0x20000.
   - Latency is 3 cycles.
   - SRAM_ADDR for the wrapping address = 0/1 (modulo wrap).

Source files
------------

// File: rtl/sram_controller.sv
// ============================================================================
// Module   : sram_controller
// Brief    : Splits 32-bit word loads/stores into two 16-bit SRAM accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_controller #(
   parameter logic [31:0] BASE_ADDR     = 32'd1024,
   parameter int          ACCESS_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        ready,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   inout  wire  [15:0] SRAM_DQ
);

   localparam int              CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOW  = 2'd1;
   localparam logic [1:0] S_HIGH = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state;
   logic [1:0]       next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             op_wr;
   logic [31:0]      addr_q;
   logic [31:0]      data_q;
   logic [31:0]      offset;
   logic [16:0]      word;
   logic             last;
   logic             drive_en;
   logic [15:0]      dq_out;
   logic             unused_offset_bits;

   // Wrapping to 2^17 words falls out of keeping only bits 18:2 of the offset.
   assign offset             = addr_q - BASE_ADDR;
   assign word               = offset[18:2];
   assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
   assign last               = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         op_wr    <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         readData <= '0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
         if (state == S_IDLE && (wr_en || rd_en)) begin
            op_wr  <= wr_en;
            addr_q <= address;
            data_q <= writeData;
         end
         if (!op_wr && last) begin
            if (state == S_LOW)
               readData[15:0] <= SRAM_DQ;
            if (state == S_HIGH)
               readData[31:16] <= SRAM_DQ;
         end
      end
   end

   always_comb begin
      next_state = state;
      cnt_next   = '0;
      case (state)
         S_IDLE: if (wr_en || rd_en) next_state = S_LOW;
         S_LOW: begin
            if (last) next_state = S_HIGH;
            else      cnt_next   = cnt + CNT_W'(1);
         end
         S_HIGH: begin
            if (last) next_state = S_DONE;
            else      cnt_next   = cnt + CNT_W'(1);
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      SRAM_ADDR = '0;
      drive_en  = 1'b0;
      dq_out    = '0;
      ready     = ~(wr_en | rd_en) | (state == S_DONE);
      case (state)
         S_LOW: begin
            SRAM_ADDR = {word, 1'b0};
            drive_en  = op_wr;
            dq_out    = data_q[15:0];
         end
         S_HIGH: begin
            SRAM_ADDR = {word, 1'b1};
            drive_en  = op_wr;
            dq_out    = data_q[31:16];
         end
         default: ;
      endcase
   end

   // The bus is driven exactly when the write strobe is low, so no contention.
   assign SRAM_WE_N = ~drive_en;
   assign SRAM_DQ   = drive_en ? dq_out : 16'hzzzz;

endmodule

`default_nettype wire
